// File: rtl/bus_io_port.sv
// bus_io_port: IO-slot responder for the system bus. Decodes a small
// register map (DATA, STATUS, CTRL, SCRATCH) and bridges bus accesses to a
// device-side TX/RX stream pair through two FIFOs.
// Optional macro BUS_IO_IRQ_EN adds the IRQ_MASK register at offset 0x04
// and a registered interrupt output; without it irq is tied low.
module bus_io_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_read_en,
  input  logic              io_write_en,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data_write,
  output logic [DATA_W-1:0] bus_data_read,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(3);
`ifdef BUS_IO_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(4);
`endif

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic              tx_en, rx_en, tx_ovf, rx_udf;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rdata;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr_act, tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
  logic ctrl_wr, flush, clr_flags, ovf_set, udf_set;

  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);

  assign tx_data  = tx_mem[tx_rd_ptr];
  assign tx_valid = tx_en && !tx_empty && !rst;
  assign rx_ready = rx_en && !rx_full && !rst;

  // A simultaneous read strobe suppresses the write entirely.
  assign wr_act      = io_write_en && !io_read_en;
  assign tx_push_req = wr_act && (bus_addr == A_DATA);
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign ovf_set     = tx_push_req && tx_full && !tx_pop;
  assign rx_pop_req  = io_read_en && (bus_addr == A_DATA);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign udf_set     = rx_pop_req && rx_empty;
  assign rx_push     = rx_valid && rx_ready;
  assign ctrl_wr     = wr_act && (bus_addr == A_CTRL);
  assign flush       = ctrl_wr && bus_data_write[3];
  assign clr_flags   = ctrl_wr && bus_data_write[2];

  // FIFO storage; no reset needed since pointers and counts guard contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus_data_write;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy; flush overrides any push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_W'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_W'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_W'(1);
    end
  end

  // Control, scratch and sticky error flags; a new error beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en   <= 1'b1;
      rx_en   <= 1'b1;
      tx_ovf  <= 1'b0;
      rx_udf  <= 1'b0;
      scratch <= '0;
    end else begin
      if (ctrl_wr) begin
        tx_en <= bus_data_write[0];
        rx_en <= bus_data_write[1];
      end
      if (wr_act && (bus_addr == A_SCRATCH)) scratch <= bus_data_write;
      tx_ovf <= (tx_ovf && !clr_flags) || ovf_set;
      rx_udf <= (rx_udf && !clr_flags) || udf_set;
    end
  end

  // STATUS layout: flags in the low byte, occupancy counts in bytes 1 and 2.
  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_full;
    status_word[1]     = tx_empty;
    status_word[2]     = rx_full;
    status_word[3]     = rx_empty;
    status_word[4]     = tx_ovf;
    status_word[5]     = rx_udf;
    status_word[15:8]  = 8'(tx_count);
    status_word[23:16] = 8'(rx_count);
  end

`ifdef BUS_IO_IRQ_EN
  logic [2:0] irq_mask;
  logic [2:0] irq_cond;

  assign irq_cond = {tx_ovf || rx_udf, tx_empty, !rx_empty};

  // Interrupt mask register and the registered interrupt line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_act && (bus_addr == A_IRQ_MASK)) irq_mask <= bus_data_write[2:0];
      irq <= |(irq_mask & irq_cond);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Zero-latency read mux, forced to zero whenever the read strobe is low.
  always_comb begin
    rdata = '0;
    if (io_read_en) begin
      case (bus_addr)
        A_DATA:    rdata = rx_empty ? '0 : rx_mem[rx_rd_ptr];
        A_STATUS:  rdata = status_word;
        A_CTRL:    rdata = DATA_W'({rx_en, tx_en});
        A_SCRATCH: rdata = scratch;
`ifdef BUS_IO_IRQ_EN
        A_IRQ_MASK: rdata = DATA_W'(irq_mask);
`endif
        default:   rdata = '0;
      endcase
    end
  end

  assign bus_data_read = rdata;

endmodule

// File: tb/tb_bus_io_port.sv
// tb_bus_io_port: scoreboard-driven bench for bus_io_port. Expected FIFO
// words are queued as stimulus is applied and popped as the DUT emits them.
// Covers the BUS_IO_IRQ_EN variant when that macro is defined.
module tb_bus_io_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_read_en = 1'b0;
  logic        io_write_en = 1'b0;
  logic [7:0]  bus_addr = '0;
  logic [31:0] bus_data_write = '0;
  logic [31:0] bus_data_read;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];

  bus_io_port #(.DATA_W(32), .ADDR_W(8), .FIFO_DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .io_read_en(io_read_en), .io_write_en(io_write_en),
    .bus_addr(bus_addr), .bus_data_write(bus_data_write),
    .bus_data_read(bus_data_read),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus and device drivers; every one starts and ends 1 time unit after a rising edge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_addr = a; bus_data_write = d; io_write_en = 1'b1;
    @(posedge clk); #1;
    io_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_addr = a; io_read_en = 1'b1;
    #4 d = bus_data_read;
    @(posedge clk); #1;
    io_read_en = 1'b0;
  endtask

  task automatic dev_push(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    rx_q.push_back(d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx(input string name);
    logic [31:0] exp;
    tx_ready = 1'b1;
    for (int c = 0; c < 20 && tx_q.size() > 0; c++) begin
      #4;
      if (tx_valid) begin
        exp = tx_q.pop_front();
        n_cmp++;
        if (tx_data !== exp) begin
          n_err++;
          $display("[TB] FAIL %s tx_data: got %h expected %h", name, tx_data, exp);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL %s drain_timeout: got %0d left expected 0", name, tx_q.size());
      tx_q.delete();
    end
    tx_ready = 1'b0;
    #4;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s tx_valid_after_drain: got %b expected 0", name, tx_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    #12;
    n_cmp++;
    if ({tx_valid, rx_ready, irq} !== 3'b000 || bus_data_read !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %b/%h expected 000/0", {tx_valid, rx_ready, irq}, bus_data_read);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_000A) begin
      n_err++; $display("[TB] FAIL reset_status: got %h expected 0000000a", r);
    end
    bus_read(8'h02, r);
    n_cmp++;
    if (r !== 32'h3) begin
      n_err++; $display("[TB] FAIL reset_ctrl: got %h expected 3", r);
    end
    bus_addr = 8'h02;
    #4;
    n_cmp++;
    if (bus_data_read !== 32'h0 || rx_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL idle_read_gated: got %h/%b expected 0/1", bus_data_read, rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tx_overflow;
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(32'h11 + i);
      bus_write(8'h00, 32'h11 + i);
    end
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_0819) begin
      n_err++; $display("[TB] FAIL tx_full_status: got %h expected 00000819", r);
    end
    drain_tx("tx_overflow");
    bus_write(8'h02, 32'h7);
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_000A) begin
      n_err++; $display("[TB] FAIL tx_ovf_cleared: got %h expected 0000000a", r);
    end
  endtask

  task automatic test_rx_underflow;
    logic [31:0] r;
    dev_push(32'hA5A5_0001);
    dev_push(32'hA5A5_0002);
    for (int i = 0; i < 2; i++) begin
      bus_read(8'h00, r);
      n_cmp++;
      if (r !== rx_q[0]) begin
        n_err++; $display("[TB] FAIL rx_data_%0d: got %h expected %h", i, r, rx_q[0]);
      end
      void'(rx_q.pop_front());
    end
    bus_read(8'h00, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_err++; $display("[TB] FAIL rx_empty_read: got %h expected 0", r);
    end
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_002A) begin
      n_err++; $display("[TB] FAIL rx_udf_status: got %h expected 0000002a", r);
    end
    bus_write(8'h02, 32'h7);
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_000A) begin
      n_err++; $display("[TB] FAIL rx_udf_cleared: got %h expected 0000000a", r);
    end
    // Device push and bus pop together on an empty RX FIFO.
    rx_data = 32'hBEE0_0001; rx_valid = 1'b1;
    rx_q.push_back(rx_data);
    bus_read(8'h00, r);
    rx_valid = 1'b0;
    n_cmp++;
    if (r !== 32'h0) begin
      n_err++; $display("[TB] FAIL rx_push_pop_empty_read: got %h expected 0", r);
    end
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0001_0022) begin
      n_err++; $display("[TB] FAIL rx_push_pop_status: got %h expected 00010022", r);
    end
    bus_write(8'h02, 32'h7);
    bus_read(8'h00, r);
    n_cmp++;
    if (r !== rx_q[0]) begin
      n_err++; $display("[TB] FAIL rx_push_pop_word: got %h expected %h", r, rx_q[0]);
    end
    void'(rx_q.pop_front());
  endtask

  task automatic test_full_push_pop;
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(32'h20 + i);
      bus_write(8'h00, 32'h20 + i);
    end
    bus_addr = 8'h00; bus_data_write = 32'h99; io_write_en = 1'b1; tx_ready = 1'b1;
    #4;
    n_cmp++;
    if (tx_data !== tx_q[0]) begin
      n_err++; $display("[TB] FAIL full_push_pop_head: got %h expected %h", tx_data, tx_q[0]);
    end
    void'(tx_q.pop_front());
    tx_q.push_back(32'h99);
    @(posedge clk); #1;
    io_write_en = 1'b0; tx_ready = 1'b0;
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_0809) begin
      n_err++; $display("[TB] FAIL full_push_pop_status: got %h expected 00000809", r);
    end
    drain_tx("full_push_pop");
  endtask

  task automatic test_scratch_unmapped;
    logic [31:0] r;
    bus_write(8'h03, 32'hDEAD_BEEF);
    bus_read(8'h03, r);
    n_cmp++;
    if (r !== 32'hDEAD_BEEF) begin
      n_err++; $display("[TB] FAIL scratch_rw: got %h expected deadbeef", r);
    end
    bus_write(8'h2A, 32'hFFFF_FFFF);
    bus_read(8'h2A, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_err++; $display("[TB] FAIL unmapped_read: got %h expected 0", r);
    end
    bus_data_write = 32'h1234_5678; io_write_en = 1'b1;
    bus_read(8'h03, r);
    io_write_en = 1'b0;
    n_cmp++;
    if (r !== 32'hDEAD_BEEF) begin
      n_err++; $display("[TB] FAIL conflict_read: got %h expected deadbeef", r);
    end
    bus_read(8'h03, r);
    n_cmp++;
    if (r !== 32'hDEAD_BEEF) begin
      n_err++; $display("[TB] FAIL conflict_no_write: got %h expected deadbeef", r);
    end
  endtask

  task automatic test_flush_enable;
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(8'h00, 32'h40 + i);
    dev_push(32'h5555_0000);
    bus_write(8'h02, 32'hB);
    rx_q.delete();
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_000A) begin
      n_err++; $display("[TB] FAIL flush_status: got %h expected 0000000a", r);
    end
    bus_read(8'h02, r);
    n_cmp++;
    if (r !== 32'h3) begin
      n_err++; $display("[TB] FAIL ctrl_self_clear: got %h expected 3", r);
    end
    bus_write(8'h02, 32'h2);
    bus_write(8'h00, 32'h55);
    tx_ready = 1'b1;
    #4;
    n_cmp++;
    if (tx_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL tx_disabled_valid: got %b expected 0", tx_valid);
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_0108) begin
      n_err++; $display("[TB] FAIL tx_disabled_status: got %h expected 00000108", r);
    end
    bus_write(8'h02, 32'h9);
    #4;
    n_cmp++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL rx_disabled_ready: got %b/%b expected 0/0", rx_ready, tx_valid);
    end
    @(posedge clk); #1;
    bus_write(8'h02, 32'h3);
  endtask

  task automatic test_irq;
    logic [31:0] r;
`ifdef BUS_IO_IRQ_EN
    bus_write(8'h04, 32'h1);
    bus_read(8'h04, r);
    n_cmp++;
    if (r !== 32'h1) begin
      n_err++; $display("[TB] FAIL irq_mask_read: got %h expected 1", r);
    end
    dev_push(32'hCAFE_0001);
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++; $display("[TB] FAIL irq_rx_set: got %b expected 1", irq);
    end
    bus_read(8'h00, r);
    n_cmp++;
    if (r !== rx_q[0]) begin
      n_err++; $display("[TB] FAIL irq_pop_data: got %h expected %h", r, rx_q[0]);
    end
    void'(rx_q.pop_front());
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("[TB] FAIL irq_rx_clear: got %b expected 0", irq);
    end
    bus_write(8'h04, 32'h0);
`else
    bus_write(8'h04, 32'h1);
    bus_read(8'h04, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_err++; $display("[TB] FAIL offset4_unmapped: got %h expected 0", r);
    end
    dev_push(32'hCAFE_0001);
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++; $display("[TB] FAIL irq_tied_low: got %b expected 0", irq);
    end
    bus_read(8'h00, r);
    n_cmp++;
    if (r !== rx_q[0]) begin
      n_err++; $display("[TB] FAIL irq_pop_data: got %h expected %h", r, rx_q[0]);
    end
    void'(rx_q.pop_front());
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    tx_ready = 1'b0;
    bus_write(8'h00, 32'h77);
    bus_write(8'h00, 32'h78);
    dev_push(32'h6666_0001);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL async_reset_outputs: got %b/%b expected 0/0", tx_valid, rx_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rx_q.delete();
    tx_q.delete();
    bus_read(8'h01, r);
    n_cmp++;
    if (r !== 32'h0000_000A) begin
      n_err++; $display("[TB] FAIL reset_mid_status: got %h expected 0000000a", r);
    end
    bus_read(8'h03, r);
    n_cmp++;
    if (r !== 32'h0) begin
      n_err++; $display("[TB] FAIL reset_mid_scratch: got %h expected 0", r);
    end
  endtask

  // Test sequence followed by the summary line.
  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_underflow();
    test_full_push_pop();
    test_scratch_unmapped();
    test_flush_enable();
    test_irq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_io_port.md
Name: bus_io_port

Overview:
- Bus-side responder (IO device end) for the 400 Mbps system bus. The bus controller is the initiator; this block answers it.
- Occupies one IO slot k. Decodes bus_addr into a small register map and returns read data in the same cycle as the read strobe.
- Bridges the bus to a device-side stream pair: a TX FIFO (bus writes, device drains) and an RX FIFO (device fills, bus reads).

Parameters:
- DATA_W, 32, bus data width (= MEM_WIDTH).
- ADDR_W, 8, register offset width (= MEM_DEPTH).
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..128.
- CNT_W, 4, occupancy counter width; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- io_read_en  in  1  this slot's bit of the controller io_read_en vector.
- io_write_en  in  1  this slot's bit of the controller io_write_en vector.
- bus_addr  in  ADDR_W  register offset.
- bus_data_write  in  DATA_W  write data.
- bus_data_read  out  DATA_W  read data; feeds bus_data_read_premux[k].
- tx_data  out  DATA_W  head of the TX FIFO.
- tx_valid  out  1  TX FIFO not empty and TX enabled.
- tx_ready  in  1  device accepts tx_data.
- rx_data  in  DATA_W  device word.
- rx_valid  in  1  device offers rx_data.
- rx_ready  out  1  RX FIFO not full and RX enabled.
- irq  out  1  interrupt (see Optional Feature).

Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.

Behaviour:
- Reset:
  - Both FIFOs empty; pointers and counts 0.
  - CTRL = 0x3 (tx_en=1, rx_en=1). SCRATCH = 0. Sticky flags = 0.
  - Outputs: bus_data_read=0, tx_valid=0, rx_ready=0, irq=0.
- Reset asserted mid-transfer discards all FIFO contents immediately.
- Read timing:
  - bus_data_read is combinational from registers and the FIFO heads, gated by io_read_en; it is 0 when io_read_en=0. This gives zero-latency read data, because the controller samples read data in the same cycle it asserts the strobe.
  - Read side effects take place at the rising edge where io_read_en=1.
- Write timing: a write takes effect at the rising edge where io_write_en=1.
- Strobe conflict: if io_read_en and io_write_en are both 1, the write is ignored and the read proceeds.
- Register map (word offsets):
  - 0x00 DATA:
    - Write pushes the TX FIFO. If TX is full, the word is dropped and tx_ovf is set.
    - Read returns the RX head and pops it. If RX is empty, the read returns 0 and sets rx_udf.
  - 0x01 STATUS (RO), bit fields:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tx_ovf, [5] rx_udf.
    - [15:8] tx_count, [23:16] rx_count, zero-extended.
    - Other bits read 0.
  - 0x02 CTRL, bit fields:
    - [0] tx_en, [1] rx_en: read/write.
    - [2] clr_flags: write-1 clears the sticky flags.
    - [3] flush: write-1 empties both FIFOs.
    - Bits [3:2] are self-clearing and read 0.
  - 0x03 SCRATCH: full-width read/write.
  - Other offsets: reads return 0; writes have no effect.
- Device side:
  - A TX pop occurs when tx_valid && tx_ready.
  - An RX push occurs when rx_valid && rx_ready.
  - Standard valid/ready rules; tx_data is stable while tx_valid=1 and tx_ready=0.
- Simultaneous events:
  - Bus push and device pop in the same cycle on a full TX FIFO: both succeed, count is unchanged, no overflow.
  - Device push and bus pop in the same cycle on an empty RX FIFO: the bus read returns 0, sets rx_udf, and the pushed word is stored (count becomes 1).
  - Flush in the same cycle as a push or pop: flush wins.
  - clr_flags in the same cycle as a new error: the flag ends set.
- Pointers are CNT_W-1 bits and wrap modulo FIFO_DEPTH. Counts range 0..FIFO_DEPTH.
- Clearing tx_en or rx_en deasserts tx_valid or rx_ready respectively. Bus access to the FIFOs is still allowed.

Optional Feature:
- Macro: BUS_IO_IRQ_EN.
- Defined:
  - Register 0x04 IRQ_MASK is read/write, reset 0. Bit fields: [0] rx_not_empty, [1] tx_empty, [2] error (tx_ovf|rx_udf).
  - irq is registered, one cycle after the condition: irq = OR of (mask & conditions).
- Not defined:
  - irq is tied to 0.
  - Offset 0x04 behaves as an unmapped offset.

Test Plan:
- Reset, then read 0x01 -> 0x0000_000A (tx_empty, rx_empty); read 0x02 -> 0x3; bus_data_read=0 when no strobe.
- tx_ready=0; write 0x00 nine times with 0x11..0x19 (FIFO_DEPTH=8). Read STATUS -> tx_full=1, tx_ovf=1, tx_count=8. Then set tx_ready=1 -> tx_data sequence 0x11..0x18, then tx_valid=0.
- Device pushes 0xA5A5_0001, 0xA5A5_0002 -> two DATA reads return the values in order. A third DATA read returns 0, and STATUS then shows rx_udf=1. Write CTRL=0x7 -> flag cleared.
- Full TX FIFO with a bus write and tx_ready=1 in the same cycle -> tx_count stays 8, tx_ovf stays 0.
- Write SCRATCH 0xDEAD_BEEF, read back the same value. Offset 0x2A reads 0. Simultaneous read and write strobes to SCRATCH -> returns the old value, and SCRATCH is unchanged.
- BUS_IO_IRQ_EN: write IRQ_MASK=0x1, device pushes one word -> irq=1 one cycle later. Pop via DATA read -> irq=0 on the next cycle.
